// File: rtl/sm4_axis_s.sv
// AXI4-Stream slave that packs 32-bit beats into 128-bit blocks for the SM4 core via a block FIFO.
// Build option: define SM4_AXIS_S_PAD_EN to zero-pad and push frames ending on a partial block.
module sm4_axis_s #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         S_AXIS_ACLK,
  input  logic         S_AXIS_ARESETN,
  input  logic [31:0]  S_AXIS_TDATA,
  input  logic [3:0]   S_AXIS_TSTRB,
  input  logic         S_AXIS_TLAST,
  input  logic         S_AXIS_TVALID,
  output logic         S_AXIS_TREADY,
  output logic [127:0] data,
  output logic         datavalid,
  input  logic         dataready,
  output logic         datalast,
  output logic         frame_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  logic [127:0]    mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [127:0]    asm_q, asm_d, blk;
  logic            ready_q, ferr_q, ferr_d;
  logic            accept, push, push_last, pop;

  // Byte strobes carry no information for this datapath.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  always_comb begin
    blk = asm_q;
    unique case (wcnt_q)
      2'd0: blk[127:96] = S_AXIS_TDATA;
      2'd1: blk[95:64]  = S_AXIS_TDATA;
      2'd2: blk[63:32]  = S_AXIS_TDATA;
      2'd3: blk[31:0]   = S_AXIS_TDATA;
    endcase

    accept    = S_AXIS_TVALID & ready_q;
    push      = 1'b0;
    push_last = 1'b0;
    ferr_d    = 1'b0;
    asm_d     = asm_q;
    wcnt_d    = wcnt_q;

    if (accept) begin
      if (wcnt_q == 2'd3) begin
        push      = 1'b1;
        push_last = S_AXIS_TLAST;
        asm_d     = '0;
        wcnt_d    = 2'd0;
      end else if (S_AXIS_TLAST) begin
`ifdef SM4_AXIS_S_PAD_EN
        // Low lanes are already zero because the assembly register is cleared after each block.
        push      = 1'b1;
        push_last = 1'b1;
`endif
        ferr_d    = 1'b1;
        asm_d     = '0;
        wcnt_d    = 2'd0;
      end else begin
        asm_d  = blk;
        wcnt_d = wcnt_q + 2'd1;
      end
    end

    pop   = (cnt_q != '0) & dataready;
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      wcnt_q  <= 2'd0;
      asm_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      ferr_q <= ferr_d;
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      // Registered from next count, so a pop on a full FIFO raises ready one cycle later.
      ready_q <= (cnt_d < DepthC);
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESETN && push) begin
      mem_data[wptr_q] <= blk;
      mem_last[wptr_q] <= push_last;
    end
  end

  assign S_AXIS_TREADY = ready_q;
  assign datavalid     = (cnt_q != '0);
  assign data          = datavalid ? mem_data[rptr_q] : '0;
  assign datalast      = datavalid ? mem_last[rptr_q] : 1'b0;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_sm4_axis_s.sv
// Directed self-checking bench for sm4_axis_s (FIFO_DEPTH = 2); follows SM4_AXIS_S_PAD_EN if defined.
module tb_sm4_axis_s;

`ifdef SM4_AXIS_S_PAD_EN
  localparam int PadEn = 1;
`else
  localparam int PadEn = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic [127:0] data;
  logic         datavalid;
  logic         dataready;
  logic         datalast;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  logic [127:0] got_data[$];
  logic         got_last[$];

  sm4_axis_s #(.FIFO_DEPTH(2)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .data          (data),
    .datavalid     (datavalid),
    .dataready     (dataready),
    .datalast      (datalast),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cyc++;
      if (datavalid && dataready) begin
        got_data.push_back(data);
        got_last.push_back(datalast);
      end
      if (tvalid && tready) acc_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tstrb = 4'hf; dataready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_data.delete(); got_last.delete();
    acc_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (tready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready timeout tready=%b required 1", tready);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    logic ok = 1'b0;
    tvalid = 1'b1; tdata = d; tlast = l;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_beat timeout beat=%h tready=%b required 1", d, tready);
    end
  endtask

  task automatic wait_blocks(input int n);
    int k = 0;
    while (got_data.size() < n && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tvalid = 1'b1; tdata = 32'hdead_beef; tlast = 1'b1; tstrb = 4'hf;
    dataready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b required 0", tready); end
    checks++; if (datavalid !== 1'b0) begin errors++; $display("FAIL reset_datavalid got %b required 0", datavalid); end
    checks++; if (data !== 128'h0) begin errors++; $display("FAIL reset_data got %h required 0", data); end
    checks++; if (datalast !== 1'b0) begin errors++; $display("FAIL reset_datalast got %b required 0", datalast); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b required 0", frame_err); end
    tvalid = 1'b0; tlast = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready got %b required 1", tready); end
  endtask

  task automatic test_full_rate();
    logic [127:0] exp;
    int c0;
    do_reset(); dataready = 1'b1; wait_ready();
    c0 = cyc;
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < 4; w++) send_beat(32'(4 * b + w + 1), (b == 7 && w == 3));
      exp = {32'(4 * b + 1), 32'(4 * b + 2), 32'(4 * b + 3), 32'(4 * b + 4)};
      checks++;
      if (datavalid !== 1'b1 || data !== exp) begin
        errors++;
        $display("FAIL full_rate_latency blk%0d got valid=%b data=%h required valid=1 data=%h",
                 b, datavalid, data, exp);
      end
    end
    checks++;
    if (cyc - c0 != 32) begin errors++; $display("FAIL full_rate_cycles got %0d required 32", cyc - c0); end
    wait_blocks(8);
    checks++;
    if (got_data.size() != 8) begin errors++; $display("FAIL full_rate_count got %0d required 8", got_data.size()); end
    checks++;
    if (got_data.size() > 0 && got_data[0] !== 128'h00000001_00000002_00000003_00000004) begin
      errors++; $display("FAIL full_rate_first got %h required 00000001000000020000000300000004", got_data[0]);
    end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      exp = {32'(4 * i + 1), 32'(4 * i + 2), 32'(4 * i + 3), 32'(4 * i + 4)};
      checks++;
      if (got_data[i] !== exp || got_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL full_rate_blk%0d got %h last=%b required %h last=%b", i, got_data[i], got_last[i],
                 exp, (i == 7));
      end
    end
    checks++;
    if (ferr_cnt != 0) begin errors++; $display("FAIL full_rate_frame_err got %0d pulses required 0", ferr_cnt); end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp [3];
    exp[0] = 128'h00000001_00000002_00000003_00000004;
    exp[1] = 128'h00000005_00000006_00000007_00000008;
    exp[2] = 128'h00000009_0000000a_0000000b_0000000c;
    do_reset(); dataready = 1'b0; wait_ready();
    for (int i = 1; i <= 8; i++) send_beat(32'(i), 1'b0);
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full got %b required 0", tready); end
    tvalid = 1'b1; tdata = 32'd9; tlast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (acc_cnt != 8) begin errors++; $display("FAIL bp_accepted got %0d required 8", acc_cnt); end
    dataready = 1'b1;
    for (int i = 9; i <= 12; i++) send_beat(32'(i), (i == 12));
    wait_blocks(3);
    checks++;
    if (got_data.size() != 3) begin errors++; $display("FAIL bp_count got %0d required 3", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      checks++;
      if (got_data[i] !== exp[i] || got_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL bp_blk%0d got %h last=%b required %h last=%b", i, got_data[i], got_last[i], exp[i],
                 (i == 2));
      end
    end
    checks++; if (acc_cnt != 12) begin errors++; $display("FAIL bp_total_beats got %0d required 12", acc_cnt); end
  endtask

  task automatic test_short_frame();
    do_reset(); dataready = 1'b1; wait_ready();
    send_beat(32'h0000_000a, 1'b0);
    send_beat(32'h0000_000b, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_ferr_pulse got %b required 1", frame_err); end
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_ferr_width got %b required 0", frame_err); end
    wait_blocks(PadEn);
    checks++;
    if (got_data.size() != PadEn) begin
      errors++; $display("FAIL short_count got %0d required %0d", got_data.size(), PadEn);
    end
`ifdef SM4_AXIS_S_PAD_EN
    checks++;
    if (got_data.size() > 0 &&
        (got_data[0] !== 128'h0000000a_0000000b_00000000_00000000 || got_last[0] !== 1'b1)) begin
      errors++;
      $display("FAIL short_pad_blk got %h last=%b required 0000000a0000000b0000000000000000 last=1",
               got_data[0], got_last[0]);
    end
`endif
    send_beat(32'h1, 1'b0); send_beat(32'h2, 1'b0); send_beat(32'h3, 1'b0); send_beat(32'h4, 1'b1);
    wait_blocks(PadEn + 1);
    checks++;
    if (got_data.size() != PadEn + 1) begin
      errors++; $display("FAIL short_next_count got %0d required %0d", got_data.size(), PadEn + 1);
    end else if (got_data[PadEn] !== 128'h00000001_00000002_00000003_00000004 || got_last[PadEn] !== 1'b1) begin
      errors++;
      $display("FAIL short_next_blk got %h last=%b required 00000001000000020000000300000004 last=1",
               got_data[PadEn], got_last[PadEn]);
    end
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL short_ferr_count got %0d required 1", ferr_cnt); end
  endtask

  task automatic test_bubbles();
    do_reset(); dataready = 1'b1; wait_ready();
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send_beat(32'(i), (i == 8));
    end
    wait_blocks(2);
    checks++;
    if (got_data.size() != 2) begin
      errors++; $display("FAIL bubbles_count got %0d required 2", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 128'h00000001_00000002_00000003_00000004 || got_last[0] !== 1'b0) begin
        errors++; $display("FAIL bubbles_blk0 got %h last=%b", got_data[0], got_last[0]);
      end
      checks++;
      if (got_data[1] !== 128'h00000005_00000006_00000007_00000008 || got_last[1] !== 1'b1) begin
        errors++; $display("FAIL bubbles_blk1 got %h last=%b", got_data[1], got_last[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); dataready = 1'b1; wait_ready();
    send_beat(32'h77, 1'b0);
    send_beat(32'h78, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tready !== 1'b0 || datavalid !== 1'b0 || data !== 128'h0 || datalast !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got tready=%b valid=%b data=%h last=%b ferr=%b required all 0",
               tready, datavalid, data, datalast, frame_err);
    end
    rst_n = 1'b1;
    wait_ready();
    for (int i = 5; i <= 8; i++) send_beat(32'(i), (i == 8));
    wait_blocks(1);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL midreset_count got %0d required 1", got_data.size());
    end else if (got_data[0] !== 128'h00000005_00000006_00000007_00000008) begin
      errors++; $display("FAIL midreset_blk got %h required 00000005000000060000000700000008", got_data[0]);
    end
  endtask

  task automatic test_full_pop();
    do_reset(); dataready = 1'b0; wait_ready();
    for (int i = 1; i <= 8; i++) send_beat(32'(i), 1'b0);
    tvalid = 1'b1; tdata = 32'h21; tlast = 1'b0;
    @(posedge clk); #1;
    dataready = 1'b1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL fullpop_tready_pop_cycle got %b required 0", tready); end
    @(posedge clk); #1;
    dataready = 1'b0;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL fullpop_tready_next got %b required 1", tready); end
    send_beat(32'h21, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (got_data.size() != 1 || acc_cnt != 9) begin
      errors++; $display("FAIL fullpop_freed got pops=%0d beats=%0d required pops=1 beats=9", got_data.size(), acc_cnt);
    end
    dataready = 1'b1;
    send_beat(32'h22, 1'b0); send_beat(32'h23, 1'b0); send_beat(32'h24, 1'b1);
    wait_blocks(3);
    checks++;
    if (got_data.size() != 3) begin
      errors++; $display("FAIL fullpop_count got %0d required 3", got_data.size());
    end else if (got_data[0] !== 128'h00000001_00000002_00000003_00000004 ||
                 got_data[1] !== 128'h00000005_00000006_00000007_00000008 ||
                 got_data[2] !== 128'h00000021_00000022_00000023_00000024) begin
      errors++; $display("FAIL fullpop_order got %h %h %h", got_data[0], got_data[1], got_data[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tstrb = 4'hf; dataready = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_short_frame();
    test_bubbles();
    test_reset_mid();
    test_full_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_axis_s.md
# sm4_axis_s

AXI4-Stream slave front end for the SM4 datapath. It accepts 32-bit beats from an upstream DMA or stream source and packs every four beats into one 128-bit block. Completed blocks are buffered in a small block FIFO and presented to the SM4 core over a `data`/`datavalid`/`dataready` handshake. It is the input-side counterpart of `sm4_axis_m`, which serialises core results back onto the stream.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: block FIFO depth in 128-bit entries; power of two, ≥ 2.

Ports:
- `S_AXIS_ACLK`  in  1  clock; all logic on the rising edge.
- `S_AXIS_ARESETN`  in  1  reset; synchronous, active-low.
- `S_AXIS_TDATA`  in  32  stream beat.
- `S_AXIS_TSTRB`  in  4  accepted and ignored; every byte is treated as valid.
- `S_AXIS_TLAST`  in  1  last beat of a frame.
- `S_AXIS_TVALID`  in  1  beat valid.
- `S_AXIS_TREADY`  out  1  slave ready.
- `data`  out  128  head-of-FIFO block.
- `datavalid`  out  1  `data` is valid.
- `dataready`  in  1  the core accepts `data`.
- `datalast`  out  1  head block closed its frame; qualified by `datavalid`.
- `frame_err`  out  1  one-cycle pulse when a frame ends on a partial block.

## Operation
- Beat acceptance: a beat is accepted when `S_AXIS_TVALID & S_AXIS_TREADY` is high.
- Word counter `wcnt` (2 bits, 0..3) selects the lane. The beat at `wcnt` = 0 goes to [127:96], 1 to [95:64], 2 to [63:32], and 3 to [31:0].
- Assembly register holds the partial block. It is cleared to zero after every push or drop.
- Push on the accepted beat when `wcnt` == 3 or `TLAST` = 1:
  - `wcnt` == 3: push the block with `datalast` = `TLAST` and set `wcnt` to 0.
  - `TLAST` with `wcnt` < 3: partial-block handling, see Configuration. `wcnt` is set to 0.
- `S_AXIS_TREADY` = reset released AND FIFO count < `FIFO_DEPTH`. It is derived only from registered state and never from `TVALID` or `TLAST`.
- FIFO: `datavalid` = FIFO not empty. `data` and `datalast` come from the head entry. A pop occurs when `datavalid & dataready`.
- Push and pop in the same cycle: count is unchanged and both pointers advance. When the FIFO is full, a same-cycle pop does not raise `TREADY` that cycle; it rises the following cycle.
- Pointers wrap modulo `FIFO_DEPTH`. The count field is one bit wider than the pointers.
- Reset (`S_AXIS_ARESETN` = 0 at a clock edge), including mid-block or mid-frame: the partial block, `wcnt`, and all FIFO contents are discarded.

## Timing
- Reset values: `S_AXIS_TREADY` 0, `datavalid` 0, `data` 0, `datalast` 0, `frame_err` 0.
- Latency: `datavalid` rises on the cycle after the edge that accepts the 4th beat (or the `TLAST` beat).
- Throughput: with `dataready` held at 1 and `FIFO_DEPTH` ≥ 2, the block sustains one beat per cycle with no bubbles.
- `data` and `datalast` stay stable while `datavalid` = 1 and `dataready` = 0.
- `frame_err` is registered. It is high exactly one cycle, the cycle after the offending `TLAST` beat is accepted.

## Configuration
- `SM4_AXIS_S_PAD_EN` defined:
  - A partial block closed by `TLAST` is zero-padded in the unfilled low lanes and pushed with `datalast` = 1.
  - `frame_err` pulses.
  - If the FIFO is full, the push is covered by `TREADY` already being low, so the beat is not accepted.
- `SM4_AXIS_S_PAD_EN` undefined:
  - The partial block is dropped and nothing is pushed.
  - `frame_err` pulses.
- In both builds, `TLAST` on the 4th beat pushes normally with no error.

## Test plan
- Full-rate stream: after reset, `dataready` = 1; stream beats 0x1, 0x2 … 0x20 (32 beats), `TLAST` on beat 32. Required: 8 blocks in order, the first `0x00000001_00000002_00000003_00000004`. `datavalid` appears 1 cycle after each 4th beat. `datalast` = 1 only on block 8. `frame_err` never pulses.
- Backpressure: `dataready` = 0, offer 12 beats. Required: `TREADY` falls after 8 accepted beats (`FIFO_DEPTH` = 2). Then raise `dataready`: all 3 blocks are delivered in order with no beat lost or duplicated.
- Short frame, `SM4_AXIS_S_PAD_EN` defined: beats 0xA, 0xB with `TLAST` on 0xB. Required: block `0x0000000A_0000000B_00000000_00000000`, `datalast` = 1, `frame_err` one-cycle pulse. Same stimulus with the macro undefined: no `datavalid`, `frame_err` pulse. The next 4-beat frame is packed correctly from lane 0.
- TVALID bubbles: the same 8 beats with random idle cycles between them. Required: blocks are identical to the bubble-free run.
- Reset mid-block: accept 2 beats, hold `S_AXIS_ARESETN` = 0 for 1 cycle, then send 0x5..0x8. Required: the only block output is `0x00000005_00000006_00000007_00000008`, and all outputs are at reset values during reset.
- Full FIFO with simultaneous pop: fill the FIFO, then pulse `dataready` for 1 cycle while `TVALID` = 1. Required: `TREADY` is still 0 in the pop cycle, rises the next cycle, and exactly one entry is freed.
